md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Iterative multiply/divide engine and scheduler for the EXE stage.
- Accepts mult/multu/div/divu from the pipeline and sequences a radix-2 shift-add multiply or restoring divide over DW cycles.
- Publishes busy/over/write-enable plus HI/LO results to the HI/LO register and forwarding logic.
- Generates the decode-stage pause for mfhi/mflo/mthi/mtlo or a new md op while an operation is in flight.

Parameters:
- DW, 32: operand width; the iteration count equals DW. Only even values ≥ 4 are supported.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- start  in  1  md instruction valid in EXE this cycle
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  DW  rs operand (multiplicand / dividend)
- b  in  DW  rt operand (multiplier / divisor)
- hilo_req  in  1  decode holds mfhi/mflo/mthi/mtlo
- busy  out  1  operation in progress (MUL or DIV state)
- over  out  1  one-cycle completion pulse
- mdcs  out  1  HI/LO write enable; equals over
- hi  out  DW  HI result (product high word / remainder)
- lo  out  DW  LO result (product low word / quotient)
- dz  out  1  last divide had divisor zero; held until the next accept
- pause  out  1  stall request to IF/ID

Behaviour:
- Clock and reset: single clock clk. Reset clrn is asynchronous, active-low.
- Reset values: state IDLE; busy=0, over=0, mdcs=0, pause=0, dz=0, hi=0, lo=0. Reset asserted mid-operation aborts immediately; no over pulse is produced.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 in cycle T accepts the op.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch the result-sign flags; clear the iteration counter.
  - Next state is MUL or DIV.
- Divisor zero: a div/divu accepted with b==0 goes straight to DONE. Result lo = all ones, hi = a (unmodified), dz=1.
- MUL:
  - Each cycle add the multiplicand to the upper accumulator when the multiplier LSB is 1, then shift the {acc, multiplier} pair right by 1.
  - After DW cycles go to DONE.
- DIV:
  - Each cycle shift {rem, quo} left by 1 and trial-subtract the divisor.
  - On a non-negative result keep the difference and set the quotient LSB.
  - After DW cycles go to DONE.
- DONE (1 cycle):
  - Apply sign correction. mult: negate the 2DW product when the operand signs differ. div: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Register hi/lo. over=1, mdcs=1, busy=0. Next state is IDLE.
- Output timing:
  - Normal latency: over is asserted in cycle T+DW+1; hi/lo are valid in that same cycle.
  - hi/lo hold their value until the next DONE.
  - busy=1 in cycles T+1 .. T+DW.
- Signed overflow: -2^(DW-1) / -1 gives lo=2^(DW-1), hi=0, from natural truncation; no exception.
- start while busy or in DONE: ignored; the op is not latched. pause covers this case.
- pause = busy & (hilo_req | start). pause=0 in DONE, because forwarding supplies hi/lo from this block in that cycle.
- Simultaneous over and start: start is ignored in DONE; the pipeline re-presents it while paused.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: in MUL, if the shifted-remaining multiplier bits are all zero after a cycle's step, the next state is DONE. The remaining accumulator shift (DW − iterations done) is applied in DONE with a barrel shift. Latency becomes 1 + (index of the highest set bit of |b|) + 1 cycles, minimum 2. DIV is unchanged.
- Undefined: MUL always takes DW cycles.

Test Plan:
- mult a=7, b=-3 (32'hFFFFFFFD) at T -> busy T+1..T+32; over/mdcs at T+33; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- multu a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 at T+33.
- div a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, dz=0; then divu a=9, b=0 -> over at T+1, lo=32'hFFFFFFFF, hi=9, dz=1.
- During busy: hilo_req=1 -> pause=1 every busy cycle; pause=0 in DONE. start pulsed with a different op mid-operation -> ignored, and the result matches the first op.
- clrn low at T+10 of a mult -> all outputs 0 immediately, no over pulse. Next start after release runs normally.
- With MD_EARLY_OUT_EN: multu a=5, b=3 at T -> over at T+3, lo=15, hi=0. Without the macro -> over at T+33, same result.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer -- iterative multiply/divide engine for the EXE stage.
//
// Runs mult/multu/div/divu on one shared datapath: a radix-2 shift-add
// multiply or a restoring divide, DW iterations each. The pipeline gets
// busy/over/mdcs, the HI/LO results, a divide-by-zero flag, and a decode
// stall request.
//
// Optional feature (compile-time macro MD_EARLY_OUT_EN):
//   When defined, a multiply finishes early once the remaining multiplier
//   bits are all zero. The remaining shift is then done in one barrel shift.
//   When undefined, a multiply always takes DW iterations.
//
// Parameters:
//   DW        operand width and iteration count (even, >= 4)
// Ports:
//   clk       clock
//   clrn      asynchronous active-low reset
//   start     md instruction valid in EXE (accepted only when idle)
//   op        00 mult, 01 multu, 10 div, 11 divu
//   a, b      rs / rt operands
//   hilo_req  decode holds mfhi/mflo/mthi/mtlo
//   busy      iterating (MUL or DIV state)
//   over      one-cycle completion pulse; hi/lo valid in the same cycle
//   mdcs      HI/LO write enable (same as over)
//   hi, lo    product high/low word, or remainder/quotient
//   dz        last divide had a zero divisor; held until the next accept
//   pause     stall request to IF/ID
module md_sequencer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          hilo_req,
    output logic          busy,
    output logic          over,
    output logic          mdcs,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          dz,
    output logic          pause
);
    localparam int            CW        = $clog2(DW);
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdState_t;

    mdState_t      state;
    logic [DW-1:0] acc;      // product high word / partial remainder
    logic [DW-1:0] low;      // multiplier shifting out / quotient shifting in
    logic [DW-1:0] opnd;     // |multiplicand| or |divisor|
    logic [CW-1:0] iterCnt;
    logic          negRes;   // negate product or quotient at the end
    logic          negRem;   // negate remainder (dividend was negative)

    // Operand conditioning at accept time.
    logic          isSigned, aNeg, bNeg;
    logic [DW-1:0] absA, absB;

    assign isSigned = ~op[0];
    assign aNeg     = isSigned & a[DW-1];
    assign bNeg     = isSigned & b[DW-1];
    assign absA     = aNeg ? -a : a;
    assign absB     = bNeg ? -b : b;

    // One iteration step for both algorithms, plus the sign-corrected final
    // result. The last step's value goes straight into hi/lo. Because of that,
    // results are already valid in the DONE cycle.
    logic [DW:0]     mulSum;
    logic [DW-1:0]   mulAcc, mulLo;
    logic [2*DW-1:0] mulAligned, mulFinal;
    logic            mulLast;
    logic [DW:0]     divTmp;
    logic            divGe;
    logic [DW-1:0]   divRem, divQuo, quoFinal, remFinal;

    // NOTE: every signal is assigned on every path through this block, so no
    // latch can be inferred.
    always_comb begin
        // The sum carries one extra bit. That bit shifts back into the
        // accumulator MSB.
        mulSum     = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        mulAcc     = mulSum[DW:1];
        mulLo      = {mulSum[0], low[DW-1:1]};
`ifdef MD_EARLY_OUT_EN
        // After iterCnt+1 shifts, the unconsumed multiplier bits are the low
        // DW-iterCnt-1 bits of mulLo. If they are all zero, every remaining
        // iteration would only shift. So do that shift here in one step.
        mulLast    = (iterCnt == LAST_ITER) ||
                     ((mulLo & ({DW{1'b1}} >> (int'(iterCnt) + 1))) == '0);
        mulAligned = {mulAcc, mulLo} >> (DW - 1 - int'(iterCnt));
`else
        mulLast    = (iterCnt == LAST_ITER);
        mulAligned = {mulAcc, mulLo};
`endif
        mulFinal   = negRes ? -mulAligned : mulAligned;

        // The shifted remainder can need DW+1 bits. Any accepted difference
        // is below the divisor, so it fits back into DW bits.
        divTmp     = {acc, low[DW-1]};
        divGe      = divTmp >= {1'b0, opnd};
        divRem     = divGe ? (divTmp[DW-1:0] - opnd) : divTmp[DW-1:0];
        divQuo     = {low[DW-2:0], divGe};
        quoFinal   = negRes ? -divQuo : divQuo;
        remFinal   = negRem ? -divRem : divRem;
    end

    // In DONE, busy is low. The forwarding path supplies hi/lo in that cycle.
    assign pause = busy & (hilo_req | start);
    assign mdcs  = over;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register updates from pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            over    <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            low     <= '0;
            opnd    <= '0;
            iterCnt <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dz      <= 1'b0;
                        iterCnt <= '0;
                        acc     <= '0;
                        negRes  <= aNeg ^ bNeg;
                        negRem  <= aNeg;
                        if (op[1]) begin
                            if (b == '0) begin
                                // Zero divisor: finish at once with a fixed result.
                                state <= DONE;
                                over  <= 1'b1;
                                hi    <= a;
                                lo    <= '1;
                                dz    <= 1'b1;
                            end else begin
                                state <= DIV;
                                busy  <= 1'b1;
                                low   <= absA;
                                opnd  <= absB;
                            end
                        end else begin
                            state <= MUL;
                            busy  <= 1'b1;
                            low   <= absB;
                            opnd  <= absA;
                        end
                    end
                end
                MUL: begin
                    acc     <= mulAcc;
                    low     <= mulLo;
                    iterCnt <= iterCnt + CW'(1);
                    if (mulLast) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        over     <= 1'b1;
                        {hi, lo} <= mulFinal;
                    end
                end
                DIV: begin
                    acc     <= divRem;
                    low     <= divQuo;
                    iterCnt <= iterCnt + CW'(1);
                    if (iterCnt == LAST_ITER) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        over  <= 1'b1;
                        hi    <= remFinal;
                        lo    <= quoFinal;
                    end
                end
                DONE: begin
                    // A start seen here is dropped. The pipeline presents it
                    // again.
                    over  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer. The stimulus process issues ops and
// queues the expected result and completion cycle, computed with native
// 64-bit arithmetic. A monitor process pops the queue and compares whenever
// over is seen.
module tb_md_sequencer;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clrn;
    logic          start = 1'b0;
    logic          hilo_req = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy, over, mdcs, dz, pause;
    logic [DW-1:0] hi, lo;

    md_sequencer #(.DW(DW)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
        .hilo_req(hilo_req), .busy(busy), .over(over), .mdcs(mdcs),
        .hi(hi), .lo(lo), .dz(dz), .pause(pause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          dz;
        int            lat;
        int            overCyc;
    } expT;

    expT sbq[$];
    expT mon;
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the arithmetic definition of each op, not an iteration.
    function automatic expT refModel(input logic [1:0] o, input logic [DW-1:0] x,
                                     input logic [DW-1:0] y);
        expT         e;
        longint      sx, sy, q, r;
        logic [63:0] p;
`ifdef MD_EARLY_OUT_EN
        logic [DW-1:0] m;
        int            msb;
`endif
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.dz  = 1'b0;
        e.lat = DW + 1;
        e.overCyc = 0;
        case (o)
            2'b00: begin
                p = 64'(sx * sy);
                e.hi = p[2*DW-1:DW];
                e.lo = p[DW-1:0];
            end
            2'b01: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[2*DW-1:DW];
                e.lo = p[DW-1:0];
            end
            default: begin
                if (y == '0) begin
                    e.hi  = x;
                    e.lo  = '1;
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else if (o == 2'b10) begin
                    q = sx / sy;   // truncates toward zero; remainder follows dividend
                    r = sx % sy;
                    e.lo = DW'(q);
                    e.hi = DW'(r);
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
`ifdef MD_EARLY_OUT_EN
        if (!o[1]) begin
            m   = (!o[0] && y[DW-1]) ? -y : y;
            msb = 0;
            for (int i = 0; i < DW; i++) if (m[i]) msb = i;
            e.lat = msb + 2;
        end
`endif
        return e;
    endfunction

    // Monitor: every over pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (clrn && over) begin
            if (sbq.size() == 0) begin
                check("spurious_over", over, 0);
            end else begin
                mon = sbq.pop_front();
                check("hi", hi, mon.hi);
                check("lo", lo, mon.lo);
                check("dz", dz, mon.dz);
                check("over_cycle", cyc, mon.overCyc);
                check("mdcs", mdcs, 1);
                check("busy_in_done", busy, 0);
            end
        end
    end

    // Issue one op, then walk its busy window. hilo_req and garbage starts
    // are toggled at random during that window.
    task automatic issue(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
        expT e;
        bit  st, hr;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        e = refModel(o, x, y);
        e.overCyc = cyc + e.lat;
        sbq.push_back(e);
        for (int k = 1; k < e.lat; k++) begin
            @(negedge clk);
            hr = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 3) == 0);
            hilo_req = hr; start = st;
            op = 2'($urandom); a = $urandom; b = $urandom;
            #1;
            check("busy", busy, 1);
            check("pause_busy", pause, hr | st);
            if (k == 1) check("dz_cleared", dz, 0);
        end
        // Completion cycle: a new start and hilo_req must not pause, and the
        // start must be ignored.
        @(negedge clk);
        hilo_req = 1'b1; start = 1'b1;
        op = 2'($urandom); a = $urandom; b = $urandom;
        #1;
        check("pause_done", pause, 0);
        @(negedge clk);
        start = 1'b0; hilo_req = 1'b0;
        check("over_seen", sbq.size(), 0);
    endtask

    // Start a mult, then pull clrn low at T+10. Everything must clear and
    // no over may follow.
    task automatic resetMidOp();
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd123; b = 32'hFFFFFFFB;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        hilo_req = 1'b1;
        #1;
        check("pause_pre_reset", pause, 1);
        clrn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_over", over, 0);
        check("rst_mdcs", mdcs, 0);
        check("rst_pause", pause, 0);
        check("rst_dz", dz, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        hilo_req = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (40) @(negedge clk);
        check("busy_after_abort", busy, 0);
    endtask

    logic [DW-1:0] corners [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1};

    function automatic logic [DW-1:0] pickOperand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return DW'($urandom_range(0, 20));
            2:       return -DW'($urandom_range(1, 20));
            default: return corners[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        clrn = 1'b1;
        #2 clrn = 1'b0;
        repeat (3) @(negedge clk);
        check("init_busy", busy, 0);
        check("init_over", over, 0);
        check("init_mdcs", mdcs, 0);
        check("init_pause", pause, 0);
        check("init_dz", dz, 0);
        check("init_hi", hi, 0);
        check("init_lo", lo, 0);
        clrn = 1'b1;

        issue(2'b00, 32'd7, 32'hFFFFFFFD);          // -21
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(2'b10, 32'hFFFFFFF9, 32'd2);          // -7 / 2
        issue(2'b11, 32'd9, 32'd0);                 // divisor zero
        issue(2'b01, 32'd5, 32'd3);                 // short multiplier
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);   // signed overflow
        issue(2'b00, 32'h80000000, 32'h80000000);
        issue(2'b10, 32'd5, 32'd0);                 // hi/lo nonzero before reset
        resetMidOp();
        issue(2'b00, 32'd7, 32'hFFFFFFFD);          // normal after abort

        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), pickOperand(), pickOperand());

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
